// File: rtl/seven_seg_scan_ctrl_if.sv
// Bundles the load request, the decimal-point inputs and the display-side outputs of
// the seven-segment scan controller. The master modport drives number/load/dp.
interface seven_seg_scan_ctrl_if #(
    parameter int INPUT_WIDTH = 14,
    parameter int NUM_DIGITS  = 4
);
    logic [INPUT_WIDTH-1:0] number;
    logic                   load;
    logic [NUM_DIGITS-1:0]  decimal_points;
    logic                   busy;
    logic [NUM_DIGITS-1:0]  anodes;
    logic [7:0]             cathodes;

    modport master (
        output number, load, decimal_points,
        input  busy, anodes, cathodes
    );

    modport slave (
        input  number, load, decimal_points,
        output busy, anodes, cathodes
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Binary-to-BCD converter (serial double dabble) feeding a multiplexed, active-low
// seven-segment scanner with leading-zero blanking and overflow dashes.
module seven_seg_scan_ctrl #(
    parameter int INPUT_WIDTH   = 14,
    parameter int NUM_DIGITS    = 4,
    parameter int PRESCALE      = 16,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    seven_seg_scan_ctrl_if.slave  bus
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;
    localparam int PS_W  = $clog2(PRESCALE);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [0:0] {ST_IDLE, ST_SHIFT} state_t;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg;
    logic [INPUT_WIDTH-1:0] sh_reg;
    logic [BCD_W-1:0]       bcd_reg;
    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W-1:0]       bcd_shift;
    logic                   shift_out;
    logic                   ovf_work_reg;
    logic [BCD_W-1:0]       res_reg;
    logic                   ovf_reg;
    logic                   busy_reg, busy_next;
    logic                   accept, last_bit, shifting;

    // ---------------- conversion FSM ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (bus.load) state_next = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        accept    = (state_reg == ST_IDLE) && bus.load;
        shifting  = (state_reg == ST_SHIFT);
        last_bit  = (cnt_reg == CNT_W'(INPUT_WIDTH - 1));
        busy_next = (state_next == ST_SHIFT);
    end

    // Add-3 correction on every digit, then shift the next binary bit in at the bottom.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
        assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                    bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end

    assign shift_out = bcd_adj[BCD_W-1];
    assign bcd_shift = {bcd_adj[BCD_W-2:0], sh_reg[INPUT_WIDTH-1]};

    // The visible result and overflow flag only change on the final shift.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_reg      <= '0;
            sh_reg       <= '0;
            bcd_reg      <= '0;
            ovf_work_reg <= 1'b0;
            res_reg      <= '0;
            ovf_reg      <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            busy_reg <= busy_next;
            if (accept) begin
                sh_reg       <= bus.number;
                bcd_reg      <= '0;
                cnt_reg      <= '0;
                ovf_work_reg <= 1'b0;
            end else if (shifting) begin
                sh_reg       <= sh_reg << 1;
                bcd_reg      <= bcd_shift;
                cnt_reg      <= cnt_reg + 1'b1;
                ovf_work_reg <= ovf_work_reg | shift_out;
                if (last_bit) begin
                    res_reg <= bcd_shift;
                    ovf_reg <= ovf_work_reg | shift_out;
                end
            end
        end
    end

    // ---------------- display scanner ----------------
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b0000001;
            4'd1:    seg_decode = 7'b1001111;
            4'd2:    seg_decode = 7'b0010010;
            4'd3:    seg_decode = 7'b0000110;
            4'd4:    seg_decode = 7'b1001100;
            4'd5:    seg_decode = 7'b0100100;
            4'd6:    seg_decode = 7'b0100000;
            4'd7:    seg_decode = 7'b0001111;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0000100;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    logic [PS_W-1:0]       presc_reg, presc_next;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic                  tick;
    logic [NUM_DIGITS-1:0] anodes_reg, anodes_next;
    logic [7:0]            cathodes_reg, cathodes_next;
    logic [NUM_DIGITS:0]   lead_zero;
    logic [6:0]            seg_arr [NUM_DIGITS];

    always_comb begin
        tick       = (presc_reg == PS_W'(PRESCALE - 1));
        presc_next = tick ? '0 : presc_reg + 1'b1;
        idx_next   = idx_reg;
        if (tick) begin
            idx_next = (idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + 1'b1;
        end
    end

    // lead_zero[k] is set when digit k and every digit above it are zero.
    assign lead_zero[NUM_DIGITS] = 1'b1;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        localparam bit CAN_BLANK = (BLANK_LEADING != 0) && (gi > 0);
        assign lead_zero[gi] = (res_reg[4*gi +: 4] == 4'd0) && lead_zero[gi+1];
        assign seg_arr[gi]   = ovf_reg                  ? 7'b1111110 :
                               (CAN_BLANK && lead_zero[gi]) ? 7'b1111111 :
                               seg_decode(res_reg[4*gi +: 4]);
        assign anodes_next[gi] = (idx_next != IDX_W'(gi));
    end

    assign cathodes_next = {seg_arr[idx_next], ~bus.decimal_points[idx_next]};

    // Anodes and cathodes switch on the same edge, so no digit ever sees another's segments.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            presc_reg    <= '0;
            idx_reg      <= '0;
            anodes_reg   <= '1;
            cathodes_reg <= 8'hFF;
        end else begin
            presc_reg    <= presc_next;
            idx_reg      <= idx_next;
            anodes_reg   <= anodes_next;
            cathodes_reg <= cathodes_next;
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.anodes   = anodes_reg;
    assign bus.cathodes = cathodes_reg;

endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
  INPUT_WIDTH, 14, binary input width; 1..(4*NUM_DIGITS+4).
  NUM_DIGITS, 4, displayed digit count; 1..8.
  PRESCALE, 16, i_clk cycles per digit slot; >= 2.
  BLANK_LEADING, 1, 1 = blank leading zeros; 0 = show all digits.
REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
  i_clk, in, 1, sole clock; all logic on rising edge.
  i_rst, in, 1, synchronous reset, active-high.
  number, in, INPUT_WIDTH, unsigned binary value; sampled only on accepted load.
  load, in, 1, single-cycle strobe requesting conversion of number.
  decimal_points, in, NUM_DIGITS, bit k = DP on for digit k (active-high); sampled live.
  busy, out, 1, conversion in progress.
  anodes, out, NUM_DIGITS, digit enables, active-low; bit k = digit k (0 = least significant).
  cathodes, out, 8, {a,b,c,d,e,f,g,dp}, active-low; bit 7 = a, bit 0 = dp.
REQ-003 The block SHALL have one clock, i_clk, and one reset, i_rst, which is synchronous and active-high.
REQ-004 All outputs SHALL be driven from registers.

Function
REQ-005 Conversion SHALL use sequential shift-and-add-3 (double dabble), processing 1 bit per cycle, MSB first.
REQ-006 A load seen while busy=0 SHALL capture number and set busy=1 on the next edge.
REQ-007 A load seen while busy=1 SHALL be ignored, with no effect on the shift register or the result.
REQ-008 busy SHALL stay high for exactly INPUT_WIDTH cycles.
REQ-009 On the edge that clears busy, the result digit registers and the overflow flag SHALL update atomically; the display SHALL never show a partial result.
REQ-010 The conversion state machine SHALL have states IDLE and SHIFT:
  - IDLE -> SHIFT on an accepted load, with the bit counter set to 0.
  - SHIFT -> IDLE when the bit counter reaches INPUT_WIDTH-1.
REQ-011 Overflow SHALL be set if any 1 bit is shifted out of the top BCD digit during a conversion; the flag is sticky per conversion and cleared at the next accepted load.
REQ-012 While overflow is set, every digit SHALL display "-" (segments 1111110) and keep its DP.
REQ-013 Segment patterns {a..g} for 0..9 SHALL be: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
REQ-014 The prescaler SHALL count 0..PRESCALE-1 and wrap; a tick SHALL occur when the count equals PRESCALE-1.
REQ-015 The scan index SHALL advance by 1 on each tick and wrap from NUM_DIGITS-1 to 0.
REQ-016 anodes SHALL equal ~(1<<idx), with exactly one bit low outside reset.
REQ-017 cathodes SHALL present digit idx, updated on the same edge as anodes, with no ghosting between digits.
REQ-018 When BLANK_LEADING=1 and there is no overflow, digit k>0 SHALL be blank (segments 1111111) if it and all higher digits are 0; digit 0 SHALL never be blanked.
REQ-019 The DP bit SHALL equal ~decimal_points[idx] regardless of blanking.
REQ-020 Scanning SHALL continue during conversion, displaying the previous result.

Reset
REQ-021 When i_rst is high at an edge, the block SHALL reset as follows:
  - state IDLE, busy=0, prescaler=0, idx=0;
  - all result digits 0, overflow=0;
  - anodes all 1, cathodes 8'hFF.
REQ-022 Reset during SHIFT SHALL abort the conversion and discard the partial result.
REQ-023 In the first cycle after reset release, anodes SHALL show digit 0 with pattern 0000001 (blanking on).

Verification
REQ-024 A bench SHALL cover these directed scenarios (defaults unless noted):
  - Reset, then load with number=1234 -> busy high for 14 cycles; idx0..3 give cathodes[7:1] = 1001100, 0000110, 0010010, 1001111; anodes cycle 1110, 1101, 1011, 0111, changing every 16 cycles and wrapping.
  - number=7, decimal_points=4'b0010 -> digit0 shows 0001111 with dp=1; digit1 shows 1111111 with dp=0; digits 2-3 show 11111111.
  - number=10000 -> overflow; all four digits show 1111110; next load of 42 clears overflow and shows "42".
  - load of 99 then load of 55 three cycles later -> 55 ignored; display shows 99.
  - i_rst pulsed mid-conversion of 9999 -> busy=0 next cycle; display shows "0"; a later load converts correctly.
  - BLANK_LEADING=0, number=5 -> display shows "0005"; NUM_DIGITS=6, INPUT_WIDTH=20, number=999999 -> all nines, no overflow.
